// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder
// Decodes framed SPI commands arriving as bytes from spi_slave and drives the
// display controller: framebuffer write port, brightness register and
// buffer-swap strobe. A frame is the span of ss high; its first byte is the
// opcode (0x01 write burst, 0x02 brightness, 0x03 swap, 0x04 fill).
//
// Optional feature macro: SPI_CMD_FILL_EN enables opcode 0x04 (framebuffer
// fill). Without it 0x04 is treated as an unknown opcode and busy is tied 0.
//
// Parameters
//   ADDR_WIDTH  framebuffer address width (9..16), write address wraps
//   BRIGHT_RST  brightness value loaded at reset
// Ports
//   clk         system clock (same domain as spi_slave)
//   rst         asynchronous reset, active-low
//   ss          raw SPI select, high = frame active (synchronised here)
//   data/valid  received byte and its 1-cycle strobe
//   fb_we       framebuffer write enable, 1-cycle pulse per written byte
//   fb_addr     framebuffer write address
//   fb_wdata    framebuffer write data
//   brightness  current brightness
//   swap        1-cycle buffer-swap strobe
//   busy        fill in progress
//   err_count   saturating count of protocol errors
module spi_cmd_decoder #(
    parameter int         ADDR_WIDTH = 12,
    parameter logic [7:0] BRIGHT_RST = 8'h80
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ss,
    input  logic [7:0]            data,
    input  logic                  valid,
    output logic                  fb_we,
    output logic [ADDR_WIDTH-1:0] fb_addr,
    output logic [7:0]            fb_wdata,
    output logic [7:0]            brightness,
    output logic                  swap,
    output logic                  busy,
    output logic [7:0]            err_count
);

    // Number of address bits carried by the ADDR_HI byte.
    localparam int HI_W = ADDR_WIDTH - 8;

    typedef enum logic [2:0] {
        IDLE, ADDR_HI, ADDR_LO, WDATA, BRIGHT, FILLV, FILL, DISCARD
    } state_t;

    state_t                state;
    logic                  ss_meta;
    logic                  ss_sync;
    logic                  ss_prev;
    logic [ADDR_WIDTH-1:0] wr_addr;

    logic                  ss_fall;
    logic                  take_byte;
    logic                  stray_byte;
    logic                  truncated;
    logic                  bad_opcode;
    logic                  fill_err;
    logic                  known_op;
    logic [1:0]            err_events;
    logic [8:0]            err_sum;
    logic [7:0]            err_next;

`ifdef SPI_CMD_FILL_EN
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic [7:0]            fill_value;
    assign known_op = (data == 8'h01) || (data == 8'h02) || (data == 8'h03) || (data == 8'h04);
    assign fill_err = valid && (state == FILL);
`else
    assign known_op = (data == 8'h01) || (data == 8'h02) || (data == 8'h03);
    assign fill_err = 1'b0;
    assign busy     = 1'b0;
`endif

    // A byte arriving on the very cycle the synchronised select falls still
    // belongs to the frame; the return to IDLE happens on the following cycle.
    assign ss_fall    = ss_prev && !ss_sync;
    assign take_byte  = valid && (ss_sync || ss_fall) && (state != FILL);
    assign stray_byte = valid && !ss_sync && !ss_fall && (state != FILL);
    assign truncated  = !ss_sync && !take_byte &&
                        (state inside {ADDR_HI, ADDR_LO, BRIGHT, FILLV});
    assign bad_opcode = take_byte && (state == IDLE) && !known_op;

    // A stray byte can coincide with a truncated frame, so up to two error
    // events may land in one cycle; the sum saturates at 8'hFF.
    assign err_events = {1'b0, stray_byte} + {1'b0, truncated} +
                        {1'b0, bad_opcode} + {1'b0, fill_err};
    assign err_sum    = {1'b0, err_count} + {7'b0, err_events};
    assign err_next   = err_sum[8] ? 8'hFF : err_sum[7:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ss_meta    <= 1'b0;
            ss_sync    <= 1'b0;
            ss_prev    <= 1'b0;
            wr_addr    <= '0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_wdata   <= 8'h00;
            brightness <= BRIGHT_RST;
            swap       <= 1'b0;
            err_count  <= 8'h00;
`ifdef SPI_CMD_FILL_EN
            busy       <= 1'b0;
            fill_addr  <= '0;
            fill_value <= 8'h00;
`endif
        end else begin
            ss_meta   <= ss;
            ss_sync   <= ss_meta;
            ss_prev   <= ss_sync;
            fb_we     <= 1'b0;
            swap      <= 1'b0;
            err_count <= err_next;

            if (take_byte) begin
                unique case (state)
                    IDLE: begin
                        case (data)
                            8'h01:   state <= ADDR_HI;
                            8'h02:   state <= BRIGHT;
                            8'h03: begin
                                swap  <= 1'b1;
                                state <= DISCARD;
                            end
`ifdef SPI_CMD_FILL_EN
                            8'h04:   state <= FILLV;
`endif
                            default: state <= DISCARD;
                        endcase
                    end
                    ADDR_HI: begin
                        wr_addr <= {data[HI_W-1:0], wr_addr[7:0]};
                        state   <= ADDR_LO;
                    end
                    ADDR_LO: begin
                        wr_addr[7:0] <= data;
                        state        <= WDATA;
                    end
                    WDATA: begin
                        fb_we    <= 1'b1;
                        fb_addr  <= wr_addr;
                        fb_wdata <= data;
                        wr_addr  <= wr_addr + ADDR_WIDTH'(1);
                    end
                    BRIGHT: begin
                        brightness <= data;
                        state      <= DISCARD;
                    end
`ifdef SPI_CMD_FILL_EN
                    FILLV: begin
                        fill_value <= data;
                        fill_addr  <= '0;
                        busy       <= 1'b1;
                        state      <= FILL;
                    end
`endif
                    default: ;
                endcase
`ifdef SPI_CMD_FILL_EN
            end else if (state == FILL) begin
                // The fill runs to completion even if the frame ends meanwhile.
                fb_we     <= 1'b1;
                fb_addr   <= fill_addr;
                fb_wdata  <= fill_value;
                fill_addr <= fill_addr + ADDR_WIDTH'(1);
                if (fill_addr == {ADDR_WIDTH{1'b1}}) begin
                    busy  <= 1'b0;
                    state <= ss_sync ? DISCARD : IDLE;
                end
`endif
            end else if (!ss_sync && (state != IDLE)) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
`timescale 1ns/1ps
// tb_spi_cmd_decoder
// Directed-vector bench. Stimulus pushes expected framebuffer writes into a
// scoreboard queue; an independent monitor pops and compares on every fb_we.
module tb_spi_cmd_decoder;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          ss;
    logic [7:0]    data;
    logic          valid;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [7:0]    fb_wdata;
    logic [7:0]    brightness;
    logic          swap;
    logic          busy;
    logic [7:0]    err_count;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    wdata;
        int            cyc;
    } wr_t;

    wr_t        exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_stamp = 0;
    int         swap_seen = 0;
    int         exp_swap = 0;
    logic [7:0] exp_err = 8'h00;

    spi_cmd_decoder #(.ADDR_WIDTH(AW), .BRIGHT_RST(8'h80)) dut (
        .clk        (clk),
        .rst        (rst),
        .ss         (ss),
        .data       (data),
        .valid      (valid),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_wdata   (fb_wdata),
        .brightness (brightness),
        .swap       (swap),
        .busy       (busy),
        .err_count  (err_count)
    );

    // Free-running clock and a cycle stamp used to check write latency.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] satInc(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    // Drives one byte for one cycle; when is_write is set the write the DUT
    // must produce one clock later is queued for the monitor.
    task automatic applyStimulus(input logic [7:0] b, input logic is_write, input logic [AW-1:0] addr);
        @(negedge clk);
        data       = b;
        valid      = 1'b1;
        last_stamp = cyc;
        if (is_write) exp_q.push_back('{addr, b, cyc + 1});
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic startFrame();
        @(negedge clk);
        ss = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic endFrame();
        @(negedge clk);
        ss = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // Monitor: scoreboard compare on every write, plus a swap pulse counter.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (swap) swap_seen++;
                if (fb_we) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_write actual=%0h/%0h expected=none", fb_addr, fb_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("wr_addr", 32'(fb_addr), 32'(e.addr));
                        checkOutput("wr_data", 32'(fb_wdata), 32'(e.wdata));
                        checkOutput("wr_cycle", 32'(cyc), 32'(e.cyc));
                    end
                end
            end
        end
    end

    // Watchdog so a stuck run still terminates.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst   = 1'b0;
        ss    = 1'b0;
        valid = 1'b0;
        data  = 8'h00;

        // Reset values.
        repeat (3) @(negedge clk);
        checkOutput("rst_fb_we", 32'(fb_we), 32'(0));
        checkOutput("rst_fb_addr", 32'(fb_addr), 32'(0));
        checkOutput("rst_fb_wdata", 32'(fb_wdata), 32'(0));
        checkOutput("rst_brightness", 32'(brightness), 32'h80);
        checkOutput("rst_swap", 32'(swap), 32'(0));
        checkOutput("rst_busy", 32'(busy), 32'(0));
        checkOutput("rst_err", 32'(err_count), 32'(0));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("post_rst_brightness", 32'(brightness), 32'h80);

        // Write burst 01 00 10 AA BB CC.
        startFrame();
        applyStimulus(8'h01, 1'b0, '0);
        applyStimulus(8'h00, 1'b0, '0);
        applyStimulus(8'h10, 1'b0, '0);
        applyStimulus(8'hAA, 1'b1, 12'h010);
        applyStimulus(8'hBB, 1'b1, 12'h011);
        applyStimulus(8'hCC, 1'b1, 12'h012);
        endFrame();

        // Address wrap: 01 0F FF 11 22.
        startFrame();
        applyStimulus(8'h01, 1'b0, '0);
        applyStimulus(8'h0F, 1'b0, '0);
        applyStimulus(8'hFF, 1'b0, '0);
        applyStimulus(8'h11, 1'b1, 12'hFFF);
        applyStimulus(8'h22, 1'b1, 12'h000);
        endFrame();
        checkOutput("err_after_writes", 32'(err_count), 32'(exp_err));

        // Brightness with trailing byte ignored.
        startFrame();
        applyStimulus(8'h02, 1'b0, '0);
        applyStimulus(8'h40, 1'b0, '0);
        applyStimulus(8'h55, 1'b0, '0);
        endFrame();
        checkOutput("brightness", 32'(brightness), 32'h40);
        checkOutput("err_after_bright", 32'(err_count), 32'(exp_err));

        // Swap strobe.
        startFrame();
        applyStimulus(8'h03, 1'b0, '0);
        exp_swap++;
        endFrame();
        checkOutput("swap_count", 32'(swap_seen), 32'(exp_swap));

        // Unknown opcode.
        startFrame();
        applyStimulus(8'h7E, 1'b0, '0);
        exp_err = satInc(exp_err);
        endFrame();
        checkOutput("err_unknown_op", 32'(err_count), 32'(exp_err));

        // Truncated write command.
        startFrame();
        applyStimulus(8'h01, 1'b0, '0);
        applyStimulus(8'h00, 1'b0, '0);
        exp_err = satInc(exp_err);
        endFrame();
        checkOutput("err_truncated", 32'(err_count), 32'(exp_err));

        // Byte outside any frame.
        applyStimulus(8'h33, 1'b0, '0);
        exp_err = satInc(exp_err);
        repeat (2) @(negedge clk);
        checkOutput("err_stray", 32'(err_count), 32'(exp_err));

`ifdef SPI_CMD_FILL_EN
        // Fill with 5A; one byte sent mid-fill counts as an error.
        startFrame();
        applyStimulus(8'h04, 1'b0, '0);
        applyStimulus(8'h5A, 1'b0, '0);
        for (int k = 0; k < (1 << AW); k++) exp_q.push_back('{AW'(k), 8'h5A, last_stamp + 2 + k});
        checkOutput("fill_busy", 32'(busy), 32'(1));
        repeat (10) @(negedge clk);
        applyStimulus(8'h99, 1'b0, '0);
        exp_err = satInc(exp_err);
        for (int i = 0; i < 6000 && busy; i++) @(negedge clk);
        checkOutput("fill_done", 32'(busy), 32'(0));
        endFrame();
        checkOutput("err_fill", 32'(err_count), 32'(exp_err));
`else
        // Opcode 04 is unknown without the fill feature; no writes follow.
        startFrame();
        applyStimulus(8'h04, 1'b0, '0);
        applyStimulus(8'h5A, 1'b0, '0);
        exp_err = satInc(exp_err);
        endFrame();
        checkOutput("err_op04", 32'(err_count), 32'(exp_err));
        checkOutput("busy_tied", 32'(busy), 32'(0));
`endif

        // Saturation of err_count.
        for (int i = 0; i < 300; i++) begin
            startFrame();
            applyStimulus(8'h7E, 1'b0, '0);
            exp_err = satInc(exp_err);
            endFrame();
        end
        checkOutput("err_saturated", 32'(err_count), 32'hFF);
        checkOutput("err_model", 32'(err_count), 32'(exp_err));

        // Reset in the middle of a write burst.
        startFrame();
        applyStimulus(8'h01, 1'b0, '0);
        applyStimulus(8'h00, 1'b0, '0);
        applyStimulus(8'h20, 1'b0, '0);
        applyStimulus(8'h33, 1'b1, 12'h020);
        rst = 1'b0;
        ss  = 1'b0;
        exp_err = 8'h00;
        #1;
        checkOutput("midrst_fb_we", 32'(fb_we), 32'(0));
        checkOutput("midrst_fb_addr", 32'(fb_addr), 32'(0));
        checkOutput("midrst_fb_wdata", 32'(fb_wdata), 32'(0));
        checkOutput("midrst_brightness", 32'(brightness), 32'h80);
        checkOutput("midrst_err", 32'(err_count), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        startFrame();
        applyStimulus(8'h01, 1'b0, '0);
        applyStimulus(8'h00, 1'b0, '0);
        applyStimulus(8'h00, 1'b0, '0);
        applyStimulus(8'h77, 1'b1, 12'h000);
        endFrame();
        checkOutput("held_wdata", 32'(fb_wdata), 32'h77);
        checkOutput("err_after_rst", 32'(err_count), 32'(exp_err));

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        checkOutput("swap_total", 32'(swap_seen), 32'(exp_swap));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
